// File: rtl/hold_bank_pkg.sv
// Shared types and helpers for the hold_bank channel bank.
package hold_bank_pkg;

    // Per-channel operating mode, two bits per channel on the mode bus.
    typedef enum logic [1:0] {
        CLEAR  = 2'b00,
        FOLLOW = 2'b01,
        SAMPLE = 2'b10,
        HOLD   = 2'b11
    } mode_e;

    // Bits needed for a counter that must reach warmup without wrapping.
    function automatic int cnt_width(input int warmup);
        return (warmup < 1) ? 1 : $clog2(warmup + 1);
    endfunction

endpackage

// File: rtl/hold_bank_chan.sv
// One channel of the bank: registered data value plus sticky changed flag.
module hold_bank_chan
    import hold_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             strobe,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] data_out,
    output logic             changed
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             changed_q;
    logic             changed_d;

    // Next data by mode; flag sets on any real change, and set beats clear.
    always_comb begin
        data_d    = data_q;
        changed_d = changed_q;
        case (mode_e'(mode))
            CLEAR:  data_d = '0;
            FOLLOW: data_d = data_in;
            SAMPLE: if (strobe) data_d = data_in;
            HOLD:   data_d = data_q;
        endcase
        changed_d = (changed_q && !clear_flags) || (data_d != data_q);
        if (rst || !run) begin
            data_d    = '0;
            changed_d = 1'b0;
        end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        data_q    <= data_d;
        changed_q <= changed_d;
    end

    assign data_out = data_q;
    assign changed  = changed_q;

endmodule

// File: rtl/hold_bank.sv
// Bank of NCH independent hold/sample channels gated by a post-reset warm-up.
module hold_bank
    import hold_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NCH    = 4,
    parameter int WARMUP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH-1:0]       strobe,
    input  logic                 clear_flags,
    output logic [NCH*WIDTH-1:0] data_out,
    output logic [NCH-1:0]       changed,
    output logic                 enabled
);

    localparam int            CW         = cnt_width(WARMUP);
    localparam logic [CW-1:0] WARM_LIMIT = CW'(WARMUP);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          enabled_q;
    logic          enabled_d;

    // Saturating warm-up count; enable goes high the cycle the count lands on the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != WARM_LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (rst) begin
            cnt_d = '0;
        end
        enabled_d = !rst && (cnt_d == WARM_LIMIT);
    end

    // Warm-up state register.
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        enabled_q <= enabled_d;
    end

    assign enabled = enabled_q;

    // Channels use the next enable so data loads on the same edge enable rises.
    for (genvar k = 0; k < NCH; k++) begin : g_chan
        hold_bank_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .run        (enabled_d),
            .mode       (mode[2*k +: 2]),
            .data_in    (data_in[k*WIDTH +: WIDTH]),
            .strobe     (strobe[k]),
            .clear_flags(clear_flags),
            .data_out   (data_out[k*WIDTH +: WIDTH]),
            .changed    (changed[k])
        );
    end

endmodule

// File: tb/tb_hold_bank.sv
// Scoreboard bench: main bank (4x32, warm-up 4) and a small bank (1x8, no warm-up).
module tb_hold_bank;

    localparam int WARM = 4;

    logic         clk;
    logic         rst;
    logic [127:0] data_in;
    logic [7:0]   mode;
    logic [3:0]   strobe;
    logic         clear_flags;
    logic [127:0] data_out;
    logic [3:0]   changed;
    logic         enabled;
    logic [7:0]   data_out_s;
    logic [0:0]   changed_s;
    logic         enabled_s;

    typedef struct {
        logic [127:0] dout;
        logic [3:0]   chg;
        logic         en;
        logic [7:0]   sdout;
        logic         schg;
        logic         sen;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference state for the main bank and the small bank.
    int          m_cnt;
    logic        m_en;
    logic [31:0] m_data [4];
    logic        m_chg  [4];
    logic [7:0]  s_data;
    logic        s_chg;

    hold_bank #(.WIDTH(32), .NCH(4), .WARMUP(WARM)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .mode       (mode),
        .strobe     (strobe),
        .clear_flags(clear_flags),
        .data_out   (data_out),
        .changed    (changed),
        .enabled    (enabled)
    );

    hold_bank #(.WIDTH(8), .NCH(1), .WARMUP(0)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in[7:0]),
        .mode       (mode[1:0]),
        .strobe     (strobe[0:0]),
        .clear_flags(clear_flags),
        .data_out   (data_out_s),
        .changed    (changed_s),
        .enabled    (enabled_s)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle, push the model's expectation, then pop and compare after the edge.
    task automatic applyStimulus(input logic r, input logic [127:0] d, input logic [7:0] m,
                                 input logic [3:0] s, input logic c);
        exp_t        e;
        exp_t        got;
        logic [31:0] nd;
        logic        nc;
        logic [7:0]  snd;
        rst         = r;
        data_in     = d;
        mode        = m;
        strobe      = s;
        clear_flags = c;
        if (r) begin
            m_cnt  = 0;
            m_en   = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_data[k] = '0;
                m_chg[k]  = 1'b0;
            end
            s_data = '0;
            s_chg  = 1'b0;
        end else begin
            if (m_cnt < WARM) m_cnt++;
            m_en = (m_cnt == WARM);
            for (int k = 0; k < 4; k++) begin
                case (m[2*k +: 2])
                    2'b00:   nd = '0;
                    2'b01:   nd = d[32*k +: 32];
                    2'b10:   nd = s[k] ? d[32*k +: 32] : m_data[k];
                    default: nd = m_data[k];
                endcase
                if (!m_en) begin
                    nd = '0;
                    nc = 1'b0;
                end else begin
                    nc = (m_chg[k] && !c) || (nd != m_data[k]);
                end
                m_data[k] = nd;
                m_chg[k]  = nc;
            end
            case (m[1:0])
                2'b00:   snd = '0;
                2'b01:   snd = d[7:0];
                2'b10:   snd = s[0] ? d[7:0] : s_data;
                default: snd = s_data;
            endcase
            s_chg  = (s_chg && !c) || (snd != s_data);
            s_data = snd;
        end
        e.dout  = {m_data[3], m_data[2], m_data[1], m_data[0]};
        e.chg   = {m_chg[3], m_chg[2], m_chg[1], m_chg[0]};
        e.en    = m_en;
        e.sdout = s_data;
        e.schg  = s_chg;
        e.sen   = !r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput("en",      enabled,      got.en);
        checkOutput("dout",    data_out,     got.dout);
        checkOutput("chg",     changed,      got.chg);
        checkOutput("s_en",    enabled_s,    got.sen);
        checkOutput("s_dout",  data_out_s,   got.sdout);
        checkOutput("s_chg",   changed_s,    got.schg);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] dall;
        logic [7:0]   rm;
        rst = 1'b1; data_in = '0; mode = '0; strobe = '0; clear_flags = 1'b0;
        @(negedge clk);

        // Reset, then warm-up with every channel following.
        d = {32'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
        applyStimulus(1'b1, d, 8'h55, 4'h0, 1'b0);
        applyStimulus(1'b1, d, 8'h55, 4'h0, 1'b0);
        checkOutput("rst_en", enabled, 1'b0);
        checkOutput("rst_dout", data_out, 128'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, d, 8'h55, 4'h0, 1'b0);
            if (i == 1) begin
                checkOutput("s_en_first", enabled_s, 1'b1);
                checkOutput("s_dout_first", data_out_s, 8'hA5);
            end
            if (i < 4) begin
                checkOutput("warm_en_low", enabled, 1'b0);
                checkOutput("warm_dout_zero", data_out[31:0], 32'h0);
            end else begin
                checkOutput("warm_en_high", enabled, 1'b1);
                checkOutput("warm_ch0", data_out[31:0], 32'hA5A5A5A5);
            end
        end
        applyStimulus(1'b0, d, 8'h55, 4'h0, 1'b1);
        checkOutput("flags_cleared", changed, 4'h0);

        // Channel 1 samples once, then holds while data moves on.
        d[63:32] = 32'h11;
        applyStimulus(1'b0, d, 8'h59, 4'b0010, 1'b0);
        d[63:32] = 32'h22;
        applyStimulus(1'b0, d, 8'h59, 4'b0000, 1'b0);
        applyStimulus(1'b0, d, 8'h59, 4'b0000, 1'b0);
        checkOutput("sample_hold", data_out[63:32], 32'h11);
        checkOutput("sample_chg", changed[1], 1'b1);

        // Channel 2 follows 5, then clears with clear_flags on the same edge.
        d[95:64] = 32'h5;
        applyStimulus(1'b0, d, 8'h59, 4'b0000, 1'b0);
        checkOutput("ch2_follow", data_out[95:64], 32'h5);
        applyStimulus(1'b0, d, 8'h49, 4'b0000, 1'b1);
        checkOutput("ch2_clear", data_out[95:64], 32'h0);
        checkOutput("ch2_set_wins", changed[2], 1'b1);

        // Channel 3 loads 0x33 then holds against toggling data and strobe.
        d[127:96] = 32'h33;
        applyStimulus(1'b0, d, 8'h59, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d[127:96] = (i % 2 == 0) ? 32'hFFFF0000 : 32'h0000FFFF;
            applyStimulus(1'b0, d, 8'hD9, (i % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0);
            checkOutput("ch3_hold", data_out[127:96], 32'h33);
            checkOutput("ch3_chg", changed[3], 1'b1);
        end

        // Reset pulse with every output nonzero, then warm-up again.
        dall = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        applyStimulus(1'b0, dall, 8'h55, 4'h0, 1'b0);
        applyStimulus(1'b1, dall, 8'h55, 4'h0, 1'b0);
        checkOutput("pulse_dout", data_out, 128'h0);
        checkOutput("pulse_chg", changed, 4'h0);
        checkOutput("pulse_en", enabled, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, dall, 8'h55, 4'h0, 1'b0);
            if (i < 4) checkOutput("rewarm_en_low", enabled, 1'b0);
            else checkOutput("rewarm_dout", data_out, dall);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 80; i++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            rm = 8'($urandom);
            applyStimulus(($urandom_range(0, 19) == 0), d, rm, 4'($urandom),
                          ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
